// File: rtl/fetch_unit.sv
// fetch_unit: PC/request FSM feeding a 2-entry instruction queue, with branch redirect to instr_pc + ImmOp.
// Define MISALIGN_TRAP_EN to halt on a misaligned redirect target and expose instr_misaligned.
module fetch_unit #(
    parameter int address_width = 32,
    parameter int data_width = 32,
    parameter logic [address_width-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst_n,
    output logic imem_req_valid,
    input  logic imem_req_ready,
    output logic [address_width-1:0] imem_addr,
    input  logic imem_rsp_valid,
    input  logic [data_width-1:0] imem_rsp_data,
    output logic [data_width-1:0] instr,
    output logic [address_width-1:0] instr_pc,
    output logic instr_valid,
    input  logic instr_ready,
    input  logic PCsrc,
    input  logic [address_width-1:0] ImmOp
`ifdef MISALIGN_TRAP_EN
    ,
    output logic instr_misaligned
`endif
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
`ifdef MISALIGN_TRAP_EN
    localparam logic [1:0] HALT = 2'd3;
`endif
    localparam logic [address_width-1:0] WORD_MASK = {{(address_width-2){1'b1}}, 2'b00};

    logic [1:0] state, state_n, seq_n, count, count_n;
    logic [address_width-1:0] fetch_pc, req_pc, target;
    logic [data_width-1:0] q_word [2];
    logic [address_width-1:0] q_pc [2];
    logic discard, consume, redirect, accept, rsp, push, slot;

    assign instr = q_word[0];
    assign instr_pc = q_pc[0];
    assign instr_valid = count != 2'd0;
    assign imem_req_valid = state == REQ;
    assign imem_addr = fetch_pc;

    assign consume = instr_valid && instr_ready;
    assign redirect = consume && PCsrc;
    assign target = (instr_pc + ImmOp) & WORD_MASK;
    assign accept = imem_req_valid && imem_req_ready;
    assign rsp = state == WAIT && imem_rsp_valid;
    // A redirect flushes everything behind the popped branch, including a same-cycle response.
    assign push = rsp && !discard && !redirect;
    assign count_n = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, consume};
    assign slot = count[1] | (count[0] & ~consume);

    assign seq_n = state == IDLE ? (count < 2'd2 ? REQ : IDLE) :
                   state == REQ  ? (accept ? WAIT : REQ) :
                   state == WAIT ? (rsp ? (count_n < 2'd2 ? REQ : IDLE) : WAIT) : state;
`ifdef MISALIGN_TRAP_EN
    assign state_n = redirect && (instr_pc[1:0] + ImmOp[1:0]) != 2'b00 ? HALT : seq_n;
    assign instr_misaligned = state == HALT;
`else
    assign state_n = seq_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 2'd0;
            discard <= 1'b0;
            fetch_pc <= RESET_PC & WORD_MASK;
            req_pc <= '0;
            q_word[0] <= '0;
            q_word[1] <= '0;
            q_pc[0] <= '0;
            q_pc[1] <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            discard <= accept ? redirect : rsp ? 1'b0 : discard | (redirect && state == WAIT);
            if (accept) req_pc <= fetch_pc;
            fetch_pc <= redirect ? target : accept ? fetch_pc + address_width'(4) : fetch_pc;
            if (consume) begin
                q_word[0] <= q_word[1];
                q_pc[0] <= q_pc[1];
            end
            if (push) begin
                q_word[slot] <= imem_rsp_data;
                q_pc[slot] <= req_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against an instruction-stream model.
// Build with MISALIGN_TRAP_EN defined to cover the trap variant.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready, PCsrc;
    logic [31:0] imem_addr, imem_rsp_data, instr, instr_pc, ImmOp;
`ifdef MISALIGN_TRAP_EN
    logic instr_misaligned;
`endif

    typedef struct {
        logic [31:0] a;
        int due;
    } req_t;
    req_t pending[$];
    logic [31:0] acc_log[$];
    logic [31:0] exp_pc = '0;
    int total = 0;
    int bad = 0;
    int cycle = 0;
    int lat = 1;
    int n_acc;
    bit halted = 1'b0;

    fetch_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PCsrc(PCsrc),
        .ImmOp(ImmOp)
`ifdef MISALIGN_TRAP_EN
        ,
        .instr_misaligned(instr_misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log events at the coming edge, advance, run the memory, check per-cycle rules.
    task automatic cyc();
        logic stall, red;
        logic [31:0] s_addr, tgt;
        stall = imem_req_valid && !imem_req_ready;
        s_addr = imem_addr;
        red = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", pending.size(), 0);
            pending.push_back('{imem_addr, cycle + lat});
            acc_log.push_back(imem_addr);
        end
        if (instr_valid && instr_ready) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, memw(exp_pc));
            red = PCsrc;
            tgt = exp_pc + ImmOp;
            if (!PCsrc) exp_pc = exp_pc + 32'd4;
`ifdef MISALIGN_TRAP_EN
            else if (tgt[1:0] != 2'b00) halted = 1'b1;
`endif
            else exp_pc = {tgt[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        if (pending.size() > 0 && pending[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = memw(pending[0].a);
            void'(pending.pop_front());
        end
        check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
        if (halted) begin
            check("halt_req", imem_req_valid, 0);
`ifdef MISALIGN_TRAP_EN
            check("halt_flag", instr_misaligned, 1);
`endif
        end else if (stall) begin
            check("req_hold", imem_req_valid, 1);
            check("req_addr", imem_addr, red ? exp_pc : s_addr);
        end
    endtask

    task automatic do_reset(input bit late);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready = 1'b0;
        PCsrc = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misaligned", instr_misaligned, 0);
`endif
        pending.delete();
        acc_log.delete();
        exp_pc = '0;
        halted = 1'b0;
        cycle = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = late;
        imem_rsp_data = 32'hDEAD_BEEF;
    endtask

    task automatic lat_check();
        for (int k = 0; k < 3; k++) begin
            check("lat_low", instr_valid, 0);
            cyc();
        end
        check("lat_high", instr_valid, 1);
    endtask

    task automatic wait_valid(input string tag);
        instr_ready = 1'b0;
        for (int i = 0; i < 60 && !instr_valid; i++) cyc();
        check(tag, instr_valid, 1);
    endtask

    task automatic reach(input logic [31:0] pc);
        for (int i = 0; i < 100 && !(instr_valid && instr_pc == pc); i++) begin
            instr_ready = 1'b1;
            cyc();
        end
        instr_ready = 1'b0;
        check("reach_pc", instr_pc, pc);
    endtask

    task automatic consume_redirect(input logic [31:0] imm);
        instr_ready = 1'b1;
        PCsrc = 1'b1;
        ImmOp = imm;
        cyc();
        instr_ready = 1'b0;
        PCsrc = 1'b0;
        ImmOp = $urandom;
    endtask

    initial begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        instr_ready = 1'b0;
        PCsrc = 1'b0;
        ImmOp = '0;
        #2;
        do_reset(1'b0);
        instr_ready = 1'b1;
        check("idle_after_release", imem_req_valid, 0);
        lat_check();
        repeat (10) cyc();
        check("seq_addr0", acc_log[0], 32'h0);
        check("seq_addr1", acc_log[1], 32'h4);
        check("seq_addr2", acc_log[2], 32'h8);
        check("seq_addr3", acc_log[3], 32'hC);

        do_reset(1'b0);
        repeat (10) cyc();
        check("stall_reqs", acc_log.size(), 2);
        check("stall_addr1", acc_log[1], 32'h4);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_instr", instr, memw(32'h0));
        check("stall_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (6) cyc();
        check("resume_addr", acc_log[2], 32'h8);

        lat = 3;
        reach(32'h10);
        repeat (8) cyc();
        consume_redirect(32'hFFFF_FFF0);
        wait_valid("flush_valid");
        check("flush_pc", instr_pc, 32'h0);

        consume_redirect(32'hFFFF_FFFC);
        wait_valid("wrap_valid");
        check("wrap_from", instr_pc, 32'hFFFF_FFFC);
        repeat (2) cyc();
        consume_redirect(32'h8);
        wait_valid("wrap_valid2");
        check("wrap_to", instr_pc, 32'h4);

        lat = 1;
        imem_req_ready = 1'b0;
        repeat (2) cyc();
        consume_redirect(32'h100);
        repeat (2) cyc();
        imem_req_ready = 1'b1;
        cyc();
        check("redir_accept", acc_log[acc_log.size()-1], 32'h104);
        wait_valid("stall_redir_valid");
        check("stall_redir_pc", instr_pc, 32'h104);

        consume_redirect(32'hFFFF_FF1C);
        wait_valid("to20_valid");
        check("to20_pc", instr_pc, 32'h20);
        consume_redirect(32'h6);
`ifdef MISALIGN_TRAP_EN
        n_acc = acc_log.size();
        repeat (5) cyc();
        check("trap_flag", instr_misaligned, 1);
        check("trap_no_req", imem_req_valid, 0);
        check("trap_empty", instr_valid, 0);
        check("trap_no_acc", acc_log.size(), n_acc);
`else
        wait_valid("mis_valid");
        check("mis_pc", instr_pc, 32'h24);
`endif

        do_reset(1'b0);
        lat = 2;
        instr_ready = 1'b1;
        repeat (2) cyc();
        check("mid_pending", pending.size(), 1);
        do_reset(1'b1);
        lat = 1;
        instr_ready = 1'b1;
        lat_check();
        repeat (4) cyc();

        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = $urandom_range(0, 3) != 0;
            instr_ready = $urandom_range(0, 2) != 0;
            PCsrc = $urandom_range(0, 7) == 0;
            ImmOp = ($urandom_range(0, 127) << 2) - 32'd256;
            lat = $urandom_range(1, 3);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "timeout");
    end
endmodule
